instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter and instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 24, meaning instruction width consumed by the decode stage.
REQ-003 SHALL have one clock; reset is synchronous and active-low. Ports: clk, input, 1, rising-edge clock; rst, input, 1, synchronous active-low reset.
REQ-004 SHALL have port imem_addr, output, PC_W, read address to the synchronous instruction memory.
REQ-005 SHALL have port imem_rdata, input, INSTR_W, memory data, valid one cycle after the address.
REQ-006 SHALL have port instr_out, output, INSTR_W, instruction presented to decode.
REQ-007 SHALL have port instr_valid, output, 1, instr_out holds a live instruction.
REQ-008 SHALL have port decode_ready, input, 1, decode accepts instr_out this cycle.
REQ-009 SHALL have port halt_in, input, 1, decode's HALT indication for the instruction on instr_out.
REQ-010 SHALL have port branch_en, input, 1, redirect request qualified by the same handshake.
REQ-011 SHALL have port branch_target, input, PC_W, redirect address.
REQ-012 SHALL have port pc_out, output, PC_W, address of the instruction on instr_out.
REQ-013 SHALL have port halted, output, 1, core stopped.
REQ-014 SHALL have port fetch_count, output, 16, count of accepted instructions.

Function
REQ-015 Handshake: instruction transfers when instr_valid and decode_ready are both high at a rising edge (an "accept").
REQ-016 States: FILL (first address issued, no data yet), RUN, HALTED. FILL->RUN after one cycle; RUN->HALTED on accept with halt_in=1; HALTED exits only via reset.
REQ-017 Latency: address on imem_addr in cycle n yields instr_valid with that instruction in cycle n+2; with decode_ready held high, throughput is one instruction per cycle.
REQ-018 PC increments by 1 per issued address, modulo 2^PC_W (address 0xFF is followed by 0x00 at default width).
REQ-019 Stall: while instr_valid=1 and decode_ready=0, instr_out, pc_out and instr_valid hold; the one in-flight read is captured in a one-entry skid buffer; no new address advances the PC.
REQ-020 When decode_ready returns high, the skid entry is presented next cycle before any new memory data; no instruction is dropped or duplicated.
REQ-021 Branch: on accept with branch_en=1, the in-flight read and the skid entry are discarded; PC loads branch_target; instr_valid is low for exactly 2 cycles; the next valid instruction is from branch_target.
REQ-022 Halt: on accept with halt_in=1, discard in-flight and skid data; instr_valid goes low and stays low; pc_out freezes at the HALT address; halted=1 from the next cycle.
REQ-023 halt_in and branch_en asserted together: halt wins and the branch is ignored.
REQ-024 halt_in and branch_en are ignored when instr_valid=0.
REQ-025 fetch_count increments by 1 on each accept, including the HALT instruction, and saturates at 0xFFFF.

Reset
REQ-026 While rst=0 at a clock edge: PC=0, imem_addr=0, instr_out=0, instr_valid=0, pc_out=0, halted=0, fetch_count=0, skid empty, state FILL.
REQ-027 Reset asserted mid-stall, mid-branch or while HALTED aborts everything; the first cycle after release issues address 0.

Structure
REQ-028 PC_W, INSTR_W and the state encoding (FILL, RUN, HALTED) SHALL live in the shared core package alongside the decode opcode constants.
REQ-029 The one-entry skid buffer (data, pc, full flag) SHALL be the sub-module fetch_skid; all other logic lives in instruction_fetch.

Verification
REQ-030 Reset release, memory mem[i]=0x000000+i, decode_ready=1 -> instr_valid first high 2 cycles after release with instr_out=0x000000, then 0x000001, 0x000002 on consecutive cycles; fetch_count=3 after 3 accepts.
REQ-031 Stall: drop decode_ready for 3 cycles while pc_out=5 -> instr_out/pc_out held at 5; on release the sequence continues 6, 7 with no gap and no repeat.
REQ-032 Branch: accept at pc 3 with branch_en=1, branch_target=0x40 -> instr_valid low for 2 cycles, next instr_out=mem[0x40], pc_out=0x40.
REQ-033 Halt: mem[7]=0xF00000, halt_in=1 on its accept -> halted=1 next cycle, instr_valid stays 0 for 20 cycles, pc_out=7, fetch_count=8.
REQ-034 Wrap and collision: run from branch_target=0xFE -> pc_out 0xFE, 0xFF, 0x00; assert halt_in and branch_en together -> HALTED, no redirect.
REQ-035 Reset mid-stall with skid full -> all outputs at REQ-026 values; after release the first instruction is mem[0].

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared core package: fetch widths, fetch FSM encoding and decode opcode constants.
package instruction_fetch_pkg;

    localparam int CORE_PC_W    = 8;
    localparam int CORE_INSTR_W = 24;

    // Fetch FSM: FILL while the first read is in flight, RUN when streaming,
    // HALTED after a HALT instruction is accepted (left only through reset).
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // Decode opcodes live in the top byte of the instruction word.
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_ALU    = 8'h10;
    localparam logic [7:0] OP_LOAD   = 8'h20;
    localparam logic [7:0] OP_STORE  = 8'h30;
    localparam logic [7:0] OP_BRANCH = 8'h40;
    localparam logic [7:0] OP_HALT   = 8'hF0;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding the memory read that lands while decode stalls.
module fetch_skid
    import instruction_fetch_pkg::*;
#(
    parameter int PC_W    = CORE_PC_W,
    parameter int INSTR_W = CORE_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_data,
    input  logic [PC_W-1:0]    push_pc,
    input  logic               pop,
    output logic               full,
    output logic [INSTR_W-1:0] data,
    output logic [PC_W-1:0]    pc
);

    // Flush beats push beats pop; push and pop never coincide in the fetch unit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full <= 1'b0;
            data <= '0;
            pc   <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            data <= push_data;
            pc   <= push_pc;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives a synchronous instruction memory and hands
// instructions to decode with a skid buffer absorbing the read in flight.
//
// Handshake: instr_out/pc_out are transferred at a rising edge where
// instr_valid && decode_ready (an accept). While instr_valid is high and
// decode_ready is low, instr_valid, instr_out and pc_out hold unchanged.
// halt_in and branch_en only take effect on an accept; halt wins over branch.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int PC_W    = CORE_PC_W,
    parameter int INSTR_W = CORE_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               decode_ready,
    input  logic               halt_in,
    input  logic               branch_en,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted,
    output logic [15:0]        fetch_count,
    output logic [1:0]         state_dbg
);

    fetch_state_e        state_q;
    fetch_state_e        state_d;
    logic [PC_W-1:0]     pc;
    logic                rd_valid;   // a read was issued last cycle, data is on imem_rdata
    logic [PC_W-1:0]     rd_pc;
    logic                accept;
    logic                halt_acc;
    logic                br_acc;
    logic                stalled;
    logic                issue;
    logic                skid_full;
    logic [INSTR_W-1:0]  skid_data;
    logic [PC_W-1:0]     skid_pc;

    assign accept    = instr_valid && decode_ready;
    assign halt_acc  = accept && halt_in;
    assign br_acc    = accept && branch_en && !halt_in;
    assign stalled   = instr_valid && !decode_ready;
    // A new address is only committed when the output can drain next cycle.
    assign issue     = (state_q != HALTED) && !stalled && !halt_acc;
    assign imem_addr = pc;
    assign halted    = (state_q == HALTED);
    assign state_dbg = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= FILL;
        else      state_q <= state_d;
    end

    // Next-state: FILL lasts one cycle, HALT accept parks the unit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    state_d = RUN;
            RUN:     if (halt_acc) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = FILL;
        endcase
    end

    // PC, read tracking, output register and accept counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= '0;
            rd_valid    <= 1'b0;
            rd_pc       <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
            fetch_count <= '0;
        end else begin
            if (halt_acc) begin
                rd_valid    <= 1'b0;
                instr_valid <= 1'b0;
            end else if (br_acc) begin
                pc          <= branch_target;
                rd_valid    <= 1'b0;
                instr_valid <= 1'b0;
            end else begin
                if (issue) begin
                    pc       <= pc + 1'b1;
                    rd_valid <= 1'b1;
                    rd_pc    <= pc;
                end else begin
                    rd_valid <= 1'b0;
                end
                // Skid entry is older than the memory data, so it goes first.
                if (!stalled) begin
                    if (skid_full) begin
                        instr_out   <= skid_data;
                        pc_out      <= skid_pc;
                        instr_valid <= 1'b1;
                    end else if (rd_valid) begin
                        instr_out   <= imem_rdata;
                        pc_out      <= rd_pc;
                        instr_valid <= 1'b1;
                    end else begin
                        instr_valid <= 1'b0;
                    end
                end
            end
            if (accept && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
        end
    end

    fetch_skid #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (halt_acc || br_acc),
        .push      (stalled && rd_valid),
        .push_data (imem_rdata),
        .push_pc   (rd_pc),
        .pop       (!stalled && skid_full),
        .full      (skid_full),
        .data      (skid_data),
        .pc        (skid_pc)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural synchronous memory.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [23:0] imem_rdata;
  logic [23:0] instr_out;
  logic        instr_valid;
  logic        decode_ready;
  logic        halt_in;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic [7:0]  pc_out;
  logic        halted;
  logic [15:0] fetch_count;
  logic [1:0]  state_dbg;

  logic [23:0] mem [256];
  int total = 0;
  int bad = 0;

  instruction_fetch #(.PC_W(8), .INSTR_W(24)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .decode_ready  (decode_ready),
    .halt_in       (halt_in),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .pc_out        (pc_out),
    .halted        (halted),
    .fetch_count   (fetch_count),
    .state_dbg     (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous memory: data one cycle after the address
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  // driver tasks: all inputs change and outputs are sampled on negedge
  task automatic apply_reset();
    rst = 1'b0;
    decode_ready = 1'b1;
    halt_in = 1'b0;
    branch_en = 1'b0;
    branch_target = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_for_pc(input logic [7:0] p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && pc_out === p) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0h expected 0", instr_valid); end
    total++; if (instr_out !== 24'h0) begin bad++; $display("FAIL reset_instr: got %0h expected 0", instr_out); end
    total++; if (pc_out !== 8'h0) begin bad++; $display("FAIL reset_pc_out: got %0h expected 0", pc_out); end
    total++; if (imem_addr !== 8'h0) begin bad++; $display("FAIL reset_addr: got %0h expected 0", imem_addr); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %0h expected 0", halted); end
    total++; if (fetch_count !== 16'h0) begin bad++; $display("FAIL reset_count: got %0h expected 0", fetch_count); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state: got %0h expected 0", state_dbg); end
  endtask

  task automatic test_stream();
    apply_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_fill_valid: got %0h expected 0", instr_valid); end
    total++; if (imem_addr !== 8'h1) begin bad++; $display("FAIL stream_fill_addr: got %0h expected 1", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (instr_valid !== 1'b1 || instr_out !== 24'(i) || pc_out !== 8'(i)) begin bad++; $display("FAIL stream_seq%0d: got v=%0h instr=%0h pc=%0h expected v=1 instr=%0h", i, instr_valid, instr_out, pc_out, i); end
    end
    @(negedge clk);
    total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL stream_count: got %0d expected 3", fetch_count); end
    total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL stream_state: got %0h expected 1", state_dbg); end
  endtask

  task automatic test_ignore_when_invalid();
    apply_reset();
    rst = 1'b1;
    halt_in = 1'b1;
    branch_en = 1'b1;
    branch_target = 8'h40;
    repeat (2) @(negedge clk);
    halt_in = 1'b0;
    branch_en = 1'b0;
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'h0 || halted !== 1'b0) begin bad++; $display("FAIL ignore_first: got v=%0h pc=%0h halted=%0h expected v=1 pc=0 halted=0", instr_valid, pc_out, halted); end
    @(negedge clk);
    total++; if (pc_out !== 8'h1 || instr_out !== 24'h1) begin bad++; $display("FAIL ignore_second: got pc=%0h instr=%0h expected 1", pc_out, instr_out); end
  endtask

  task automatic test_stall();
    bit ok;
    apply_reset();
    rst = 1'b1;
    wait_for_pc(8'h5, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_reach: got timeout expected pc 5"); end
    decode_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (instr_valid !== 1'b1 || pc_out !== 8'h5 || instr_out !== 24'h5 || imem_addr !== 8'h7) begin bad++; $display("FAIL stall_hold%0d: got v=%0h pc=%0h instr=%0h addr=%0h expected 1/5/5/7", i, instr_valid, pc_out, instr_out, imem_addr); end
    end
    decode_ready = 1'b1;
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'h6 || instr_out !== 24'h6) begin bad++; $display("FAIL stall_resume6: got v=%0h pc=%0h instr=%0h expected 1/6/6", instr_valid, pc_out, instr_out); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'h7 || instr_out !== 24'h7) begin bad++; $display("FAIL stall_resume7: got v=%0h pc=%0h instr=%0h expected 1/7/7", instr_valid, pc_out, instr_out); end
    total++; if (fetch_count !== 16'd7) begin bad++; $display("FAIL stall_count: got %0d expected 7", fetch_count); end
  endtask

  task automatic test_branch();
    bit ok;
    apply_reset();
    rst = 1'b1;
    wait_for_pc(8'h3, ok);
    total++; if (!ok) begin bad++; $display("FAIL branch_reach: got timeout expected pc 3"); end
    branch_en = 1'b1;
    branch_target = 8'h40;
    @(negedge clk);
    branch_en = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL branch_gap1: got %0h expected 0", instr_valid); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL branch_gap2: got %0h expected 0", instr_valid); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'h40 || instr_out !== 24'h40) begin bad++; $display("FAIL branch_target: got v=%0h pc=%0h instr=%0h expected 1/40/40", instr_valid, pc_out, instr_out); end
    total++; if (fetch_count !== 16'd4) begin bad++; $display("FAIL branch_count: got %0d expected 4", fetch_count); end
    @(negedge clk);
    total++; if (pc_out !== 8'h41 || instr_out !== 24'h41) begin bad++; $display("FAIL branch_next: got pc=%0h instr=%0h expected 41", pc_out, instr_out); end
  endtask

  task automatic test_halt();
    bit ok;
    int seen_valid;
    mem[7] = 24'hF00000;
    apply_reset();
    rst = 1'b1;
    wait_for_pc(8'h7, ok);
    total++; if (!ok || instr_out !== 24'hF00000) begin bad++; $display("FAIL halt_reach: got ok=%0d instr=%0h expected 1/f00000", ok, instr_out); end
    halt_in = 1'b1;
    @(negedge clk);
    halt_in = 1'b0;
    total++; if (halted !== 1'b1 || state_dbg !== 2'd2) begin bad++; $display("FAIL halt_flag: got halted=%0h state=%0h expected 1/2", halted, state_dbg); end
    total++; if (fetch_count !== 16'd8) begin bad++; $display("FAIL halt_count: got %0d expected 8", fetch_count); end
    seen_valid = 0;
    branch_en = 1'b1;
    branch_target = 8'h20;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid !== 1'b0) seen_valid++;
    end
    branch_en = 1'b0;
    total++; if (seen_valid != 0) begin bad++; $display("FAIL halt_quiet: got %0d valid cycles expected 0", seen_valid); end
    total++; if (pc_out !== 8'h7 || halted !== 1'b1 || fetch_count !== 16'd8) begin bad++; $display("FAIL halt_frozen: got pc=%0h halted=%0h count=%0d expected 7/1/8", pc_out, halted, fetch_count); end
    mem[7] = 24'h7;
  endtask

  task automatic test_wrap_collision();
    bit ok;
    apply_reset();
    rst = 1'b1;
    wait_for_pc(8'h3, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_reach: got timeout expected pc 3"); end
    branch_en = 1'b1;
    branch_target = 8'hFE;
    @(negedge clk);
    branch_en = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'hFE || instr_out !== 24'hFE) begin bad++; $display("FAIL wrap_fe: got v=%0h pc=%0h instr=%0h expected 1/fe/fe", instr_valid, pc_out, instr_out); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'hFF || instr_out !== 24'hFF) begin bad++; $display("FAIL wrap_ff: got v=%0h pc=%0h instr=%0h expected 1/ff/ff", instr_valid, pc_out, instr_out); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'h00 || instr_out !== 24'h00) begin bad++; $display("FAIL wrap_00: got v=%0h pc=%0h instr=%0h expected 1/0/0", instr_valid, pc_out, instr_out); end
    halt_in = 1'b1;
    branch_en = 1'b1;
    branch_target = 8'h80;
    @(negedge clk);
    halt_in = 1'b0;
    branch_en = 1'b0;
    total++; if (halted !== 1'b1 || instr_valid !== 1'b0 || pc_out !== 8'h00) begin bad++; $display("FAIL collide_halt: got halted=%0h v=%0h pc=%0h expected 1/0/0", halted, instr_valid, pc_out); end
    total++; if (fetch_count !== 16'd7) begin bad++; $display("FAIL collide_count: got %0d expected 7", fetch_count); end
    repeat (5) @(negedge clk);
    total++; if (instr_valid !== 1'b0 || pc_out !== 8'h00 || halted !== 1'b1) begin bad++; $display("FAIL collide_no_redirect: got v=%0h pc=%0h halted=%0h expected 0/0/1", instr_valid, pc_out, halted); end
  endtask

  task automatic test_reset_mid_stall();
    bit ok;
    apply_reset();
    rst = 1'b1;
    wait_for_pc(8'h4, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstall_reach: got timeout expected pc 4"); end
    decode_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    decode_ready = 1'b1;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0 || instr_out !== 24'h0 || pc_out !== 8'h0 || imem_addr !== 8'h0) begin bad++; $display("FAIL rstall_outputs: got v=%0h instr=%0h pc=%0h addr=%0h expected all 0", instr_valid, instr_out, pc_out, imem_addr); end
    total++; if (fetch_count !== 16'h0 || halted !== 1'b0 || state_dbg !== 2'd0) begin bad++; $display("FAIL rstall_state: got count=%0h halted=%0h state=%0h expected all 0", fetch_count, halted, state_dbg); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rstall_fill: got %0h expected 0", instr_valid); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'h0 || instr_out !== 24'h0) begin bad++; $display("FAIL rstall_first: got v=%0h pc=%0h instr=%0h expected 1/0/0", instr_valid, pc_out, instr_out); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'h1 || instr_out !== 24'h1) begin bad++; $display("FAIL rstall_second: got v=%0h pc=%0h instr=%0h expected 1/1/1", instr_valid, pc_out, instr_out); end
  endtask

  task automatic test_saturate();
    apply_reset();
    rst = 1'b1;
    // count at the k-th negedge after release is k-2
    repeat (65536) @(negedge clk);
    total++; if (fetch_count !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe: got %0h expected fffe", fetch_count); end
    @(negedge clk);
    total++; if (fetch_count !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff: got %0h expected ffff", fetch_count); end
    repeat (3) @(negedge clk);
    total++; if (fetch_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %0h expected ffff", fetch_count); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 24'(i);
    rst = 1'b0;
    decode_ready = 1'b1;
    halt_in = 1'b0;
    branch_en = 1'b0;
    branch_target = 8'h00;
    test_reset();
    test_stream();
    test_ignore_when_invalid();
    test_stall();
    test_branch();
    test_halt();
    test_wrap_collision();
    test_reset_mid_stall();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
